dpr_access_arbiter: RTL and testbench
=====================================

// Module: dpr_access_arbiter
// PURPOSE
//  Shares the 16x8 dual-port RAM between two write clients and two read clients.
//  Round-robin arbitration on each RAM port: write port (WEN/DI/A0/PEN0) and read port (A1/PEN1/DO1).
//  Registers the RAM command and returns read data with a per-client valid strobe.
//  Sits between the client logic and the DPR instance; it is the only block that drives the RAM pins.
// PARAMETERS
//  DW  8  data width; must match the RAM
//  AW  4  address width; RAM depth = 2**AW
// PORTS
//  CLK      in   1   system clock, rising edge
//  RSTN     in   1   asynchronous, active-low reset
//  WREQ0/1  in   1   write request, client 0/1
//  WADDR0/1 in   AW  write address, client 0/1
//  WDATA0/1 in   DW  write data, client 0/1
//  WGNT0/1  out  1   write grant, client 0/1 (combinational)
//  RREQ0/1  in   1   read request, client 0/1
//  RADDR0/1 in   AW  read address, client 0/1
//  RGNT0/1  out  1   read grant, client 0/1 (combinational)
//  RVALID0/1 out 1   read data valid, client 0/1 (registered)
//  RDATA    out  DW  read data, shared; qualified by RVALIDx
//  WEN      out  1   RAM write enable (registered)
//  PEN0     out  1   RAM port-0 enable (registered)
//  A0       out  AW  RAM write address (registered)
//  DI       out  DW  RAM write data (registered)
//  PEN1     out  1   RAM port-1 enable (registered)
//  A1       out  AW  RAM read address (registered)
//  DO1      in   DW  RAM read data; valid the cycle after PEN1/A1 are sampled
// BEHAVIOUR
//  Handshake:
//   - Client holds REQ, ADDR and DATA stable until it sees GNT.
//   - Transfer is accepted on the rising edge where REQ&GNT=1.
//   - Client may issue a new request in the next cycle; each port sustains 1 transfer/cycle.
//  Arbitration (independent per port, combinational from REQ and pointer):
//   - One requester: it is granted.
//   - Both requesting: grant goes to the client NOT granted last on that port.
//   - No request: no grant, and the pointer holds.
//   - Pointers WLAST and RLAST update only on an accepted transfer.
//  Latency (grant cycle = N):
//   - Write: WEN=PEN0=1 with A0/DI in N+1; the RAM commits at the end of N+1.
//   - Read: PEN1=1 with A1 in N+1; RVALIDx=1 for exactly one cycle in N+2.
//   - In N+2, RDATA=DO1 (combinational passthrough, or the bypass value below).
//  Idle cycles: WEN=PEN0=PEN1=0; A0/A1/DI hold their last values; RVALID0=RVALID1=0.
//  Tags: the read client tag is pipelined with the command; RVALID0 and RVALID1 are never both 1.
//  Same-address write and read issued to the RAM in the same cycle: behaviour is set by CONFIGURATION.
//  Reset (RSTN=0, any time, including mid-transfer):
//   - All registered outputs go to 0 immediately.
//   - WLAST=RLAST=1, so client 0 wins the first contention.
//   - In-flight reads are dropped and produce no RVALID.
//   - Grants are 0 while RSTN=0.
//  Address wrap is not applicable: the full AW range is valid and there is no bounds check.
// CONFIGURATION
//  WR_RD_BYPASS_EN defined:
//   - If WEN & PEN1 and A0==A1 in the same cycle, RDATA in the following cycle is that cycle's DI.
//   - Implemented with a 1-cycle forward register plus a match flag.
//  WR_RD_BYPASS_EN undefined: RDATA is always DO1 (the RAM returns the old data on collision).
// TESTING
//  1. Reset: RSTN low with requests active -> all outputs 0; after release, an idle bus gives WEN=PEN1=0.
//  2. Single writer: WREQ0 for addr 0..15, data 1..16 -> WGNT0 every cycle; WEN,A0=i-1,DI=i one cycle later.
//  3. Write contention: WREQ0=WREQ1=1 held for 4 cycles -> grants alternate 0,1,0,1; RAM sees interleaved writes.
//  4. Read back: RREQ1 for addr 0..15 after test 2 -> RVALID1 at N+2 with RDATA=addr+1, one per cycle.
//  5. Collision: write 0xAA to addr 5 while reading addr 5 (old 0x06) -> RDATA=0xAA with WR_RD_BYPASS_EN, 0x06 without.
//  6. Mid-read reset: pulse RSTN low in cycle N+1 of a read -> no RVALID; RLAST=1 afterward.

Source files
------------

// File: rtl/dpr_access_arbiter.sv
// dpr_access_arbiter
//   Shares one 16x8 dual-port RAM between two write clients and two read
//   clients. Each RAM port has its own two-way round-robin arbiter. The
//   granted command is registered onto the RAM pins. Read data comes back
//   two cycles after the grant, with a one-hot per-client valid strobe.
//
// Parameters
//   DW  data width (must match the RAM)
//   AW  address width, RAM depth = 2**AW
//
// Ports
//   CLK, RSTN              clock (rising edge), async active-low reset
//   WREQx/WADDRx/WDATAx    write client x request, address, data
//   WGNTx                  write grant (combinational)
//   RREQx/RADDRx           read client x request, address
//   RGNTx                  read grant (combinational)
//   RVALIDx                read data valid for client x (registered)
//   RDATA                  shared read data, qualified by RVALIDx
//   WEN/PEN0/A0/DI         RAM write port (registered)
//   PEN1/A1                RAM read port (registered)
//   DO1                    RAM read data, valid the cycle after PEN1/A1
//
// Optional feature (macro WR_RD_BYPASS_EN)
//   When defined, a write and a read to the same address on the RAM pins in
//   the same cycle return the write data on RDATA in the next cycle. When
//   undefined, RDATA is always DO1, so the read returns the old contents.

// Two-client round-robin arbiter with a sticky "last granted" pointer.
module dpr_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic last;  // index of the client granted most recently

  always_comb begin
    gnt = 2'b00;
    if (rst_n) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  // gnt is a subset of req, so any grant is an accepted transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    last <= 1'b1;
    else if (|gnt) last <= gnt[1];
  end
endmodule

module dpr_access_arbiter #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          WREQ0,
  input  logic [AW-1:0] WADDR0,
  input  logic [DW-1:0] WDATA0,
  input  logic          WREQ1,
  input  logic [AW-1:0] WADDR1,
  input  logic [DW-1:0] WDATA1,
  output logic          WGNT0,
  output logic          WGNT1,
  input  logic          RREQ0,
  input  logic [AW-1:0] RADDR0,
  input  logic          RREQ1,
  input  logic [AW-1:0] RADDR1,
  output logic          RGNT0,
  output logic          RGNT1,
  output logic          RVALID0,
  output logic          RVALID1,
  output logic [DW-1:0] RDATA,
  output logic          WEN,
  output logic          PEN0,
  output logic [AW-1:0] A0,
  output logic [DW-1:0] DI,
  output logic          PEN1,
  output logic [AW-1:0] A1,
  input  logic [DW-1:0] DO1
);
  localparam int NPORT  = 2;  // 0 = write port, 1 = read port
  localparam int STAGES = 1;  // read pipe: [0] command on RAM, [1] data back

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_cmd_t;

  // ---------------------------------------------------------------- arbiters
  logic [NPORT-1:0][1:0] req;
  logic [NPORT-1:0][1:0] gnt;

  assign req[0] = {WREQ1, WREQ0};
  assign req[1] = {RREQ1, RREQ0};

  for (genvar p = 0; p < NPORT; p++) begin : g_arb
    dpr_rr_arb2 u_arb (
      .clk   (CLK),
      .rst_n (RSTN),
      .req   (req[p]),
      .gnt   (gnt[p])
    );
  end

  assign WGNT0 = gnt[0][0];
  assign WGNT1 = gnt[0][1];
  assign RGNT0 = gnt[1][0];
  assign RGNT1 = gnt[1][1];

  // ------------------------------------------------------------- write port
  wr_cmd_t wsel;
  always_comb begin
    wsel = '{addr: WADDR0, data: WDATA0};
    if (gnt[0][1]) wsel = '{addr: WADDR1, data: WDATA1};
  end

  logic    wen_q;
  wr_cmd_t wcmd_q;

  // Address/data hold their last value on idle cycles.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wen_q  <= 1'b0;
      wcmd_q <= '0;
    end else begin
      wen_q <= |gnt[0];
      if (|gnt[0]) wcmd_q <= wsel;
    end
  end

  assign WEN  = wen_q;
  assign PEN0 = wen_q;
  assign A0   = wcmd_q.addr;
  assign DI   = wcmd_q.data;

  // -------------------------------------------------------------- read port
  // vld_pipe carries the one-hot client tag with the command, so the valid
  // strobes can never both be set. Reset empties it, dropping in-flight reads.
  logic [STAGES:0][1:0] vld_pipe;
  logic                 pen1_q;
  logic [AW-1:0]        a1_q;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      vld_pipe <= '0;
      pen1_q   <= 1'b0;
      a1_q     <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], gnt[1]};
      pen1_q   <= |gnt[1];
      if (|gnt[1]) a1_q <= gnt[1][1] ? RADDR1 : RADDR0;
    end
  end

  assign PEN1    = pen1_q;
  assign A1      = a1_q;
  assign RVALID0 = vld_pipe[STAGES][0];
  assign RVALID1 = vld_pipe[STAGES][1];

`ifdef WR_RD_BYPASS_EN
  // The RAM returns old data when a read and a write to the same address hit
  // the pins together. Capture the write data so the reader sees the new
  // value in the following cycle.
  logic          byp_hit;
  logic [DW-1:0] byp_data;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      byp_hit  <= 1'b0;
      byp_data <= '0;
    end else begin
      byp_hit  <= wen_q & pen1_q & (wcmd_q.addr == a1_q);
      byp_data <= wcmd_q.data;
    end
  end

  assign RDATA = byp_hit ? byp_data : DO1;
`else
  assign RDATA = DO1;
`endif

endmodule

// File: tb/tb_dpr_access_arbiter.sv
module tb_dpr_access_arbiter;
  localparam int DW = 8;
  localparam int AW = 4;

`ifdef WR_RD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          wreq0 = 0, wreq1 = 0, rreq0 = 0, rreq1 = 0;
  logic [AW-1:0] waddr0 = 0, waddr1 = 0, raddr0 = 0, raddr1 = 0;
  logic [DW-1:0] wdata0 = 0, wdata1 = 0;
  logic          wgnt0, wgnt1, rgnt0, rgnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata, di, do1;
  logic          wen, pen0, pen1;
  logic [AW-1:0] a0, a1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dpr_access_arbiter #(.DW(DW), .AW(AW)) dut (
    .CLK(clk), .RSTN(rstn),
    .WREQ0(wreq0), .WADDR0(waddr0), .WDATA0(wdata0),
    .WREQ1(wreq1), .WADDR1(waddr1), .WDATA1(wdata1),
    .WGNT0(wgnt0), .WGNT1(wgnt1),
    .RREQ0(rreq0), .RADDR0(raddr0), .RREQ1(rreq1), .RADDR1(raddr1),
    .RGNT0(rgnt0), .RGNT1(rgnt1),
    .RVALID0(rvalid0), .RVALID1(rvalid1), .RDATA(rdata),
    .WEN(wen), .PEN0(pen0), .A0(a0), .DI(di),
    .PEN1(pen1), .A1(a1), .DO1(do1)
  );

  // Stand-in for the dual-port RAM: synchronous read, old data on collision.
  logic [DW-1:0] ram [16];
  initial begin
    for (int i = 0; i < 16; i++) ram[i] = '0;
    do1 = '0;
  end
  always @(posedge clk) begin
    if (pen1)        do1 <= ram[a1];
    if (wen && pen0) ram[a0] <= di;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  // Transaction-level view: an accepted write lands on the RAM pins the next
  // cycle; an accepted read reaches the pins the next cycle and returns the
  // memory contents (before that cycle's write, unless bypass) one cycle later.
  logic [DW-1:0] ref_mem [16];
  initial for (int i = 0; i < 16; i++) ref_mem[i] = '0;

  bit            m_wlast = 1, m_rlast = 1;  // client granted last, per port
  bit            w1_v = 0, r1_v = 0, r2_v = 0;
  bit            r1_c, r2_c;
  logic [AW-1:0] w1_a = 0, r1_a = 0;
  logic [DW-1:0] w1_d = 0, r2_d = 0;

  function automatic logic [1:0] exp_gnt(input logic rq0, input logic rq1,
                                         input bit last, input logic rn);
    if (!rn || (!rq0 && !rq1)) return 2'b00;
    if (rq0 && rq1) return last ? 2'b01 : 2'b10;  // the one not served last
    return rq1 ? 2'b10 : 2'b01;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_wlast = 1; m_rlast = 1;
      w1_v = 0; r1_v = 0; r2_v = 0;
      w1_a = 0; w1_d = 0; r1_a = 0;
    end else begin
      logic [1:0] gw, gr;
      gw = exp_gnt(wreq0, wreq1, m_wlast, 1'b1);
      gr = exp_gnt(rreq0, rreq1, m_rlast, 1'b1);
      r2_v = r1_v;
      r2_c = r1_c;
      if (r1_v) r2_d = (BYP && w1_v && w1_a == r1_a) ? w1_d : ref_mem[r1_a];
      if (w1_v) ref_mem[w1_a] = w1_d;
      w1_v = (gw != 0);
      if (w1_v) begin
        w1_a    = gw[1] ? waddr1 : waddr0;
        w1_d    = gw[1] ? wdata1 : wdata0;
        m_wlast = gw[1];
      end
      r1_v = (gr != 0);
      if (r1_v) begin
        r1_c    = gr[1];
        r1_a    = gr[1] ? raddr1 : raddr0;
        m_rlast = gr[1];
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    chk("wgnt", {wgnt1, wgnt0}, exp_gnt(wreq0, wreq1, m_wlast, rstn));
    chk("rgnt", {rgnt1, rgnt0}, exp_gnt(rreq0, rreq1, m_rlast, rstn));
    chk("wen_pen0", {wen, pen0}, {w1_v, w1_v});
    chk("a0_di", {a0, di}, {w1_a, w1_d});
    chk("pen1_a1", {pen1, a1}, {r1_v, r1_a});
    chk("rvalid", {rvalid1, rvalid0}, {r2_v && r2_c, r2_v && !r2_c});
    if (r2_v) chk("rdata", rdata, r2_d);
  end

  // ------------------------------------------------------------- stimulus
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rstn = 1'b0;
    #2;
    rstn = 1'b1;
  endtask

  initial begin
    // 1: reset with requests active
    #1;
    rstn = 1'b0;
    wreq0 = 1; rreq0 = 1; waddr0 = 4'd3; wdata0 = 8'h33; raddr0 = 4'd3;
    @(negedge clk);
    chk("rst_gnt", {wgnt0, wgnt1, rgnt0, rgnt1}, 4'b0);
    chk("rst_regs", {wen, pen0, pen1, a0, a1, di, rvalid0, rvalid1}, '0);
    step(); step();
    wreq0 = 0; rreq0 = 0;
    rstn = 1'b1;
    step();
    @(negedge clk);
    chk("idle_wen_pen1", {wen, pen1}, 2'b00);

    // 2: single writer fills addr i with i+1
    for (int i = 0; i < 16; i++) begin
      step();
      wreq0 = 1; waddr0 = AW'(i); wdata0 = DW'(i + 1);
      @(negedge clk);
      chk("t2_wgnt0", wgnt0, 1);
      if (i > 0) chk("t2_cmd", {wen, a0, di}, {1'b1, 4'(i - 1), 8'(i)});
    end
    step();
    wreq0 = 0;
    @(negedge clk);
    chk("t2_last_cmd", {wen, a0, di}, {1'b1, 4'd15, 8'd16});

    // 4: read back every address through client 1
    for (int i = 0; i < 18; i++) begin
      step();
      rreq1 = (i < 16); raddr1 = AW'(i);
      @(negedge clk);
      if (i < 16) chk("t4_rgnt1", rgnt1, 1);
      if (i >= 2) chk("t4_rd", {rvalid1, rvalid0, rdata}, {2'b10, 8'(i - 1)});
    end
    step();
    rreq1 = 0;

    // 3: write contention after reset, client 0 wins first
    pulse_reset();
    wreq0 = 1; waddr0 = 4'd8; wdata0 = 8'h80;
    wreq1 = 1; waddr1 = 4'd9; wdata1 = 8'h90;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t3_wgnt", {wgnt1, wgnt0}, (k % 2 == 0) ? 2'b01 : 2'b10);
      if (k > 0) chk("t3_a0", a0, (k % 2 == 1) ? 4'd8 : 4'd9);
      step();
    end
    wreq0 = 0; wreq1 = 0;
    @(negedge clk);
    chk("t3_last_a0", {wen, a0, di}, {1'b1, 4'd9, 8'h90});

    // 5: same-address write and read reach the RAM together
    step();
    wreq0 = 1; waddr0 = 4'd5; wdata0 = 8'hAA;
    rreq0 = 1; raddr0 = 4'd5;
    @(negedge clk);
    chk("t5_gnt", {wgnt0, rgnt0}, 2'b11);
    step();
    wreq0 = 0; rreq0 = 0;
    @(negedge clk);
    chk("t5_pins", {wen, pen1, a0, a1}, {2'b11, 4'd5, 4'd5});
    step();
    @(negedge clk);
    chk("t5_rdata", {rvalid0, rdata}, {1'b1, BYP ? 8'hAA : 8'h06});

    // 6: reset during cycle N+1 of a client-0 read
    step();
    rreq0 = 1; raddr0 = 4'd3;
    step();
    rreq0 = 0;
    pulse_reset();
    @(negedge clk);
    chk("t6_pen1", pen1, 0);
    step();
    @(negedge clk);
    chk("t6_rvalid", {rvalid1, rvalid0}, 2'b00);
    step();
    rreq0 = 1; rreq1 = 1; raddr0 = 4'd1; raddr1 = 4'd2;
    @(negedge clk);
    chk("t6_rlast", {rgnt1, rgnt0}, 2'b01);
    step();
    rreq0 = 0; rreq1 = 0;
    repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t expected < 100000", $time);
    $fatal(1);
  end
endmodule
